// File: rtl/prefix_adder_arbiter.sv
// prefix_adder_arbiter
//   Shares one 8-bit parallel-prefix (Kogge-Stone) adder among NUM_REQ
//   requesters. Round-robin arbitration picks one operand pair per cycle, the
//   sum lands in a single registered response slot tagged with the winner ID.
//
// Handshake (both sides): a transfer happens on a rising clk edge where
//   valid & ready are both high. A requester must hold valid/a/b stable until
//   it sees its ready bit. The response slot holds rsp_* stable while
//   rsp_valid=1 and rsp_ready=0. A drain and a refill may occur on the same edge.

// Pure combinational 8-bit Kogge-Stone adder, no carry-in.
module prefix_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH:0]   sum_o
);

  // Generate/propagate prefix tree; log2(WIDTH) combining levels.
  function automatic logic [WIDTH:0] ks_add(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] hs;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g_n;
    logic [WIDTH-1:0] p_n;
    logic [WIDTH:0]   res;
    hs  = a ^ b;
    g   = a & b;
    p   = hs;
    g_n = g;
    p_n = p;
    for (int d = 1; d < WIDTH; d = d * 2) begin
      g_n = g;
      p_n = p;
      for (int i = d; i < WIDTH; i++) begin
        g_n[i] = g[i] | (p[i] & g[i-d]);
        p_n[i] = p[i] & p[i-d];
      end
      g = g_n;
      p = p_n;
    end
    // After the tree, g[i] is the carry out of bit i (group generate 0..i).
    res        = '0;
    res[0]     = hs[0];
    for (int i = 1; i < WIDTH; i++) begin
      res[i] = hs[i] ^ g[i-1];
    end
    res[WIDTH] = g[WIDTH-1];
    return res;
  endfunction

  // Sum of the two operands through the prefix tree.
  always_comb begin
    sum_o = ks_add(a_i, b_i);
  end

endmodule

module prefix_adder_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int WIDTH   = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH:0]           rsp_sum,
  output logic [ID_W-1:0]          rsp_id,
  output logic [15:0]              txn_count
);

  // Response slot state; rsp_valid is a direct decode of it, so the state is
  // always observable at the boundary.
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  slot_state_e      state_q, state_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [WIDTH:0]   sum_q, sum_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [15:0]      txn_count_q, txn_count_d;

  logic             slot_free;
  logic             found;
  logic [ID_W-1:0]  win_id;
  logic             grant;
  logic [WIDTH-1:0] win_a;
  logic [WIDTH-1:0] win_b;
  logic [WIDTH:0]   add_sum;

  // The slot can take a new result if it is empty or is being drained now.
  assign slot_free = (state_q == SLOT_EMPTY) | rsp_ready;

  // Round-robin search: first valid requester at or above the pointer, wrapping.
  always_comb begin
    int              idx;
    logic [ID_W-1:0] cand;
    found  = 1'b0;
    win_id = '0;
    idx    = 0;
    cand   = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = int'(ptr_q) + off;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      cand = ID_W'(idx);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        win_id = cand;
      end
    end
  end

  // No grant while reset is asserted so nothing is accepted and then discarded.
  assign grant = found & slot_free & ~reset;

  // One-hot ready toward the winner only.
  always_comb begin
    req_ready = '0;
    if (grant) begin
      req_ready[win_id] = 1'b1;
    end
  end

  // Operand mux feeding the single shared adder.
  always_comb begin
    win_a = req_a[int'(win_id)*WIDTH +: WIDTH];
    win_b = req_b[int'(win_id)*WIDTH +: WIDTH];
  end

  prefix_adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .a_i   (win_a),
    .b_i   (win_b),
    .sum_o (add_sum)
  );

  // Slot FSM next state plus all register updates tied to a grant.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    sum_d       = sum_q;
    id_d        = id_q;
    txn_count_d = txn_count_q;

    case (state_q)
      SLOT_EMPTY: begin
        if (grant) begin
          state_d = SLOT_FULL;
        end
      end
      SLOT_FULL: begin
        if (rsp_ready && !grant) begin
          state_d = SLOT_EMPTY;
        end
      end
      default: begin
        state_d = SLOT_EMPTY;
      end
    endcase

    if (grant) begin
      sum_d       = add_sum;
      id_d        = win_id;
      txn_count_d = txn_count_q + 16'd1;
      if (int'(win_id) == NUM_REQ - 1) begin
        ptr_d = '0;
      end else begin
        ptr_d = win_id + 1'b1;
      end
    end
  end

  // State and datapath registers; async assert, sync release by design of the driver.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= SLOT_EMPTY;
      ptr_q       <= '0;
      sum_q       <= '0;
      id_q        <= '0;
      txn_count_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      sum_q       <= sum_d;
      id_q        <= id_d;
      txn_count_q <= txn_count_d;
    end
  end

  assign rsp_valid = (state_q == SLOT_FULL);
  assign rsp_sum   = sum_q;
  assign rsp_id    = id_q;
  assign txn_count = txn_count_q;

endmodule

// File: tb/tb_prefix_adder_arbiter.sv
// Directed, table-driven bench for prefix_adder_arbiter (NUM_REQ=4, WIDTH=8).
module tb_prefix_adder_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int WIDTH   = 8;

  // Default operands: req0 FF+01, req1 12+34, req2 AF+FA, req3 F1+F9.
  localparam logic [31:0] A_DEF = 32'hF1AF12FF;
  localparam logic [31:0] B_DEF = 32'hF9FA3401;

  logic                     clk;
  logic                     reset;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [WIDTH:0]           rsp_sum;
  logic [ID_W-1:0]          rsp_id;
  logic [15:0]              txn_count;

  int checks;
  int failures;

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] a;
    logic [31:0] b;
    logic        rr;
    logic [3:0]  exp_ready;
    logic        exp_rv;
    logic [8:0]  exp_sum;
    logic [1:0]  exp_id;
    logic [15:0] exp_txn;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs[NVEC];

  prefix_adder_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W),
    .WIDTH   (WIDTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_id    (rsp_id),
    .txn_count (txn_count)
  );

  // Clock: 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic [31:0] a, input logic [31:0] b,
                       input logic rr);
    req_valid = v;
    req_a     = a;
    req_b     = b;
    rsp_ready = rr;
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // Rows run back to back from reset (pointer 0, slot empty).
    vecs[0]  = '{4'b0001, A_DEF, B_DEF, 1'b1, 4'b0001, 1'b1, 9'h100, 2'd0, 16'd1};
    vecs[1]  = '{4'b0000, A_DEF, B_DEF, 1'b1, 4'b0000, 1'b0, 9'h100, 2'd0, 16'd1};
    vecs[2]  = '{4'b1111, A_DEF, B_DEF, 1'b1, 4'b0010, 1'b1, 9'h046, 2'd1, 16'd2};
    vecs[3]  = '{4'b1111, A_DEF, B_DEF, 1'b1, 4'b0100, 1'b1, 9'h1A9, 2'd2, 16'd3};
    vecs[4]  = '{4'b1111, A_DEF, B_DEF, 1'b1, 4'b1000, 1'b1, 9'h1EA, 2'd3, 16'd4};
    vecs[5]  = '{4'b1111, A_DEF, B_DEF, 1'b1, 4'b0001, 1'b1, 9'h100, 2'd0, 16'd5};
    vecs[6]  = '{4'b1111, A_DEF, B_DEF, 1'b1, 4'b0010, 1'b1, 9'h046, 2'd1, 16'd6};
    // Fill the slot with FF+FF from requester 2, then stall three cycles.
    vecs[7]  = '{4'b0100, 32'hF1FF12FF, 32'hF9FF3401, 1'b1, 4'b0100, 1'b1, 9'h1FE, 2'd2, 16'd7};
    vecs[8]  = '{4'b1111, A_DEF, B_DEF, 1'b0, 4'b0000, 1'b1, 9'h1FE, 2'd2, 16'd7};
    vecs[9]  = '{4'b1111, A_DEF, B_DEF, 1'b0, 4'b0000, 1'b1, 9'h1FE, 2'd2, 16'd7};
    vecs[10] = '{4'b1111, A_DEF, B_DEF, 1'b0, 4'b0000, 1'b1, 9'h1FE, 2'd2, 16'd7};
    // Drain and refill on the same edge; pointer stayed at 3 through the stall.
    vecs[11] = '{4'b1111, A_DEF, B_DEF, 1'b1, 4'b1000, 1'b1, 9'h1EA, 2'd3, 16'd8};
    // Bring pointer to 2, then requesters 1 and 3 alternate.
    vecs[12] = '{4'b0010, A_DEF, B_DEF, 1'b1, 4'b0010, 1'b1, 9'h046, 2'd1, 16'd9};
    vecs[13] = '{4'b1010, A_DEF, B_DEF, 1'b1, 4'b1000, 1'b1, 9'h1EA, 2'd3, 16'd10};
    vecs[14] = '{4'b1010, A_DEF, B_DEF, 1'b1, 4'b0010, 1'b1, 9'h046, 2'd1, 16'd11};
    // Requester 0 (CC+BB) raised while pointer=2: waits one grant, then served.
    vecs[15] = '{4'b1011, 32'hF1AF12CC, 32'hF9FA34BB, 1'b1, 4'b1000, 1'b1, 9'h1EA, 2'd3, 16'd12};
    vecs[16] = '{4'b1011, 32'hF1AF12CC, 32'hF9FA34BB, 1'b1, 4'b0001, 1'b1, 9'h187, 2'd0, 16'd13};
    // Slot full, consumer stalled, nobody requesting: everything holds.
    vecs[17] = '{4'b0000, A_DEF, B_DEF, 1'b0, 4'b0000, 1'b1, 9'h187, 2'd0, 16'd13};

    // Reset phase with requests pending: no grant, all outputs at reset values.
    reset = 1'b1;
    drive(4'b1111, A_DEF, B_DEF, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_sum", 32'(rsp_sum), 32'd0);
    chk("reset_rsp_id", 32'(rsp_id), 32'd0);
    chk("reset_txn", 32'(txn_count), 32'd0);
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    drive(4'b0000, A_DEF, B_DEF, 1'b1);
    reset = 1'b0;

    // Table: drive at negedge, check ready before the edge, results after it.
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive(vecs[i].valid, vecs[i].a, vecs[i].b, vecs[i].rr);
      #1;
      chk($sformatf("v%0d_req_ready", i), 32'(req_ready), 32'(vecs[i].exp_ready));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].exp_rv));
      chk($sformatf("v%0d_rsp_sum", i), 32'(rsp_sum), 32'(vecs[i].exp_sum));
      chk($sformatf("v%0d_rsp_id", i), 32'(rsp_id), 32'(vecs[i].exp_id));
      chk($sformatf("v%0d_txn", i), 32'(txn_count), 32'(vecs[i].exp_txn));
    end

    // Reset while FULL with requests pending: clears immediately (async).
    @(negedge clk);
    drive(4'b1111, A_DEF, B_DEF, 1'b0);
    reset = 1'b1;
    #1;
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_txn", 32'(txn_count), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("midrst_hold_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    // After release requesters 1 and 0 valid: pointer back at 0 so req 0 wins.
    drive(4'b0011, A_DEF, B_DEF, 1'b1);
    #1;
    chk("postrst_req_ready", 32'(req_ready), 32'b0001);
    @(posedge clk);
    #1;
    chk("postrst_rsp_id", 32'(rsp_id), 32'd0);
    chk("postrst_rsp_sum", 32'(rsp_sum), 32'h100);
    chk("postrst_txn", 32'(txn_count), 32'd1);

    // Counter wrap: preload 0xFFFF, then one more grant.
    @(negedge clk);
    drive(4'b0000, A_DEF, B_DEF, 1'b1);
    force dut.txn_count_q = 16'hFFFF;
    #1;
    release dut.txn_count_q;
    #1;
    chk("wrap_preload", 32'(txn_count), 32'hFFFF);
    @(negedge clk);
    drive(4'b1000, A_DEF, B_DEF, 1'b1);
    @(posedge clk);
    #1;
    chk("wrap_txn", 32'(txn_count), 32'h0000);
    chk("wrap_rsp_sum", 32'(rsp_sum), 32'h1EA);
    @(negedge clk);
    drive(4'b0000, A_DEF, B_DEF, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
